// File: rtl/motor_mixer_arm.sv
// motor_mixer_arm
//   Mixes throttle with signed roll/pitch/yaw corrections into NUM_MOTORS motor commands.
//   A per-motor sign table selects add or subtract for each axis. The mixed set is
//   desaturated against OUT_MAX and then clamped to [IDLE, OUT_MAX].
//   An arming FSM gates all output. A link-loss failsafe ramps the motors down to zero.
//   Every published word is offered to the PWM encoder over a valid/ready handshake.
//
// Ports
//   clk          system clock
//   RST          asynchronous active-low reset
//   frame_valid  1-cycle pulse, new PPM frame (samples arm_sw and throttle)
//   throttle     unsigned throttle command
//   arm_sw       arm switch level
//   corr_valid   1-cycle pulse, roll/pitch/yaw corrections valid (samples throttle too)
//   roll_corr    signed roll correction
//   pitch_corr   signed pitch correction
//   yaw_corr     signed yaw correction
//   motor_out    packed motor commands, motor0 in the LSBs
//   out_valid    motor_out holds a word not yet transferred
//   out_ready    encoder accepts the word when out_valid && out_ready
//   state        0 disarmed, 1 arming, 2 armed, 3 failsafe
//   failsafe     high while in the failsafe state
module motor_mixer_arm #(
    parameter int unsigned             NUM_MOTORS = 4,
    parameter int unsigned             CMD_W      = 10,
    parameter int unsigned             CORR_W     = 12,
    parameter int unsigned             OUT_MAX    = 999,
    parameter int unsigned             IDLE       = 50,
    parameter logic [3*NUM_MOTORS-1:0] MIX_SIGN   = 12'b000_110_011_101,
    parameter int unsigned             ARM_FRAMES = 50,
    parameter int unsigned             FS_TIMEOUT = 25000,
    parameter int unsigned             RAMP_DIV   = 1000,
    parameter int unsigned             RAMP_STEP  = 4
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic                          frame_valid,
    input  logic [CMD_W-1:0]              throttle,
    input  logic                          arm_sw,
    input  logic                          corr_valid,
    input  logic signed [CORR_W-1:0]      roll_corr,
    input  logic signed [CORR_W-1:0]      pitch_corr,
    input  logic signed [CORR_W-1:0]      yaw_corr,
    output logic [NUM_MOTORS*CMD_W-1:0]   motor_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [1:0]                    state,
    output logic                          failsafe
);

    // Sum width leaves headroom for three full-scale corrections on top of throttle.
    localparam int unsigned SumW   = ((CMD_W + 1 > CORR_W) ? CMD_W + 1 : CORR_W) + 2;
    // One extra bit so subtracting the desaturation excess can never wrap.
    localparam int unsigned DiffW  = SumW + 1;
    localparam int unsigned TmrW   = $clog2(FS_TIMEOUT + 1);
    localparam int unsigned ArmW   = $clog2(ARM_FRAMES + 1);
    localparam int unsigned RampW  = $clog2(RAMP_DIV + 1);

    localparam logic [TmrW-1:0]         TmrMax   = TmrW'(FS_TIMEOUT);
    localparam logic [ArmW-1:0]         ArmLast  = ArmW'(ARM_FRAMES - 1);
    localparam logic [RampW-1:0]        RampLast = RampW'(RAMP_DIV - 1);
    localparam logic [CMD_W-1:0]        IdleCmd  = CMD_W'(IDLE);
    localparam logic [CMD_W-1:0]        MaxCmd   = CMD_W'(OUT_MAX);
    localparam logic [CMD_W-1:0]        StepCmd  = CMD_W'(RAMP_STEP);
    localparam logic signed [DiffW-1:0] IdleS    = DiffW'(IDLE);
    localparam logic signed [DiffW-1:0] MaxS     = DiffW'(OUT_MAX);

    typedef enum logic [1:0] {
        StDisarmed = 2'd0,
        StArming   = 2'd1,
        StArmed    = 2'd2,
        StFailsafe = 2'd3
    } state_e;

    state_e                  state_q;
    logic [TmrW-1:0]         link_q;
    logic                    timeout;
    logic [ArmW-1:0]         arm_cnt_q;
    logic [RampW-1:0]        ramp_cnt_q;
    logic [CMD_W-1:0]        motor_q [NUM_MOTORS];
    logic                    out_valid_q;

    logic signed [SumW-1:0]  thr_ext;
    logic signed [SumW-1:0]  roll_ext;
    logic signed [SumW-1:0]  pitch_ext;
    logic signed [SumW-1:0]  yaw_ext;
    logic signed [SumW-1:0]  sum_d [NUM_MOTORS];
    logic signed [SumW-1:0]  sum_q [NUM_MOTORS];
    logic                    s1_valid_q;

    logic signed [DiffW-1:0] sum_ext [NUM_MOTORS];
    logic signed [DiffW-1:0] adj [NUM_MOTORS];
    logic signed [DiffW-1:0] peak;
    logic signed [DiffW-1:0] excess;
    logic [CMD_W-1:0]        mix_cmd [NUM_MOTORS];
    logic [CMD_W-1:0]        ramp_cmd [NUM_MOTORS];
    logic                    all_zero;

    logic                    qualify;
    logic                    leave_armed;

    // ------------------------------------------------------------------
    // Link-loss timer: saturates so timeout stays asserted until a frame arrives.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            link_q <= '0;
        end else if (frame_valid) begin
            link_q <= '0;
        end else if (link_q != TmrMax) begin
            link_q <= link_q + TmrW'(1);
        end
    end

    assign timeout = (link_q == TmrMax);

    always_comb begin
        qualify     = frame_valid && arm_sw && (throttle < IdleCmd);
        leave_armed = (state_q == StArmed) && ((frame_valid && !arm_sw) || timeout);
    end

    // ------------------------------------------------------------------
    // Stage 1: per-motor signed sums using the sign table.
    // ------------------------------------------------------------------
    always_comb begin
        thr_ext   = {{(SumW - CMD_W){1'b0}}, throttle};
        roll_ext  = {{(SumW - CORR_W){roll_corr[CORR_W-1]}}, roll_corr};
        pitch_ext = {{(SumW - CORR_W){pitch_corr[CORR_W-1]}}, pitch_corr};
        yaw_ext   = {{(SumW - CORR_W){yaw_corr[CORR_W-1]}}, yaw_corr};
        for (int i = 0; i < int'(NUM_MOTORS); i++) begin
            sum_d[i] = thr_ext;
            sum_d[i] = MIX_SIGN[3*i]   ? sum_d[i] - roll_ext  : sum_d[i] + roll_ext;
            sum_d[i] = MIX_SIGN[3*i+1] ? sum_d[i] - pitch_ext : sum_d[i] + pitch_ext;
            sum_d[i] = MIX_SIGN[3*i+2] ? sum_d[i] - yaw_ext   : sum_d[i] + yaw_ext;
        end
    end

    // In-flight sums are dropped on the same edge the FSM leaves the armed state.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            s1_valid_q <= 1'b0;
            for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                sum_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= corr_valid && (state_q == StArmed) && !leave_armed;
            if (corr_valid) begin
                for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                    sum_q[i] <= sum_d[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shift the whole set down so the largest motor sits at OUT_MAX,
    // which preserves the attitude differential, then clamp each motor.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < int'(NUM_MOTORS); i++) begin
            sum_ext[i] = {sum_q[i][SumW-1], sum_q[i]};
        end
        peak = sum_ext[0];
        for (int i = 1; i < int'(NUM_MOTORS); i++) begin
            if (sum_ext[i] > peak) begin
                peak = sum_ext[i];
            end
        end
        excess = (peak > MaxS) ? peak - MaxS : '0;
        for (int i = 0; i < int'(NUM_MOTORS); i++) begin
            adj[i] = sum_ext[i] - excess;
            if (adj[i] > MaxS) begin
                mix_cmd[i] = MaxCmd;
            end else if (adj[i] < IdleS) begin
                mix_cmd[i] = IdleCmd;
            end else begin
                mix_cmd[i] = adj[i][CMD_W-1:0];
            end
        end
    end

    // Failsafe ramp step, floored at zero.
    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < int'(NUM_MOTORS); i++) begin
            ramp_cmd[i] = (motor_q[i] > StepCmd) ? motor_q[i] - StepCmd : '0;
            if (motor_q[i] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Arming / failsafe FSM with registered motor word and handshake.
    // A publish later in this block overrides the accept-clear, so a new
    // word arriving on the accept edge keeps out_valid high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q     <= StDisarmed;
            arm_cnt_q   <= '0;
            ramp_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                motor_q[i] <= '0;
            end
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                StDisarmed: begin
                    arm_cnt_q  <= '0;
                    ramp_cnt_q <= '0;
                    if (qualify) begin
                        if (ARM_FRAMES <= 1) begin
                            state_q     <= StArmed;
                            out_valid_q <= 1'b1;
                            for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                                motor_q[i] <= IdleCmd;
                            end
                        end else begin
                            state_q   <= StArming;
                            arm_cnt_q <= ArmW'(1);
                        end
                    end
                end
                StArming: begin
                    if ((frame_valid && !qualify) || timeout) begin
                        state_q     <= StDisarmed;
                        out_valid_q <= 1'b1;
                        for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                            motor_q[i] <= '0;
                        end
                    end else if (qualify) begin
                        if (arm_cnt_q == ArmLast) begin
                            state_q     <= StArmed;
                            out_valid_q <= 1'b1;
                            for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                                motor_q[i] <= IdleCmd;
                            end
                        end else begin
                            arm_cnt_q <= arm_cnt_q + ArmW'(1);
                        end
                    end
                end
                StArmed: begin
                    if (frame_valid && !arm_sw) begin
                        state_q     <= StDisarmed;
                        out_valid_q <= 1'b1;
                        for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                            motor_q[i] <= '0;
                        end
                    end else if (timeout) begin
                        // Motors hold their last command until the first ramp step.
                        state_q    <= StFailsafe;
                        ramp_cnt_q <= '0;
                    end else if (s1_valid_q) begin
                        out_valid_q <= 1'b1;
                        for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                            motor_q[i] <= mix_cmd[i];
                        end
                    end
                end
                StFailsafe: begin
                    if (all_zero) begin
                        state_q     <= StDisarmed;
                        out_valid_q <= 1'b1;
                    end else if (ramp_cnt_q == RampLast) begin
                        ramp_cnt_q  <= '0;
                        out_valid_q <= 1'b1;
                        for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                            motor_q[i] <= ramp_cmd[i];
                        end
                    end else begin
                        ramp_cnt_q <= ramp_cnt_q + RampW'(1);
                    end
                end
                default: state_q <= StDisarmed;
            endcase
        end
    end

    always_comb begin
        motor_out = '0;
        for (int i = 0; i < int'(NUM_MOTORS); i++) begin
            motor_out[i*CMD_W +: CMD_W] = motor_q[i];
        end
    end

    assign out_valid = out_valid_q;
    assign state     = state_q;
    assign failsafe  = (state_q == StFailsafe);

endmodule
